// File: rtl/interrupt_acknowledge_control_pkg.sv
// Shared definitions for the interrupt acknowledge controller:
// acknowledge-cycle state encoding, IR count and the spurious level.
package interrupt_acknowledge_control_pkg;

    // Number of interrupt request lines handled by the controller.
    localparam int unsigned IR_COUNT = 8;

    // Width of an IR level index.
    localparam int unsigned LEVEL_WIDTH = 3;

    // Level reported in the vector when the first INTA finds nothing to serve.
    localparam logic [LEVEL_WIDTH-1:0] SPURIOUS_INDEX = 3'd7;

    // Acknowledge handshake states.
    typedef enum logic [2:0] {
        IDLE,
        INT_PENDING,
        ACK1,
        WAIT2,
        ACK2
    } ack_state_t;

    // One-hot mask selecting a single IR level.
    function automatic logic [IR_COUNT-1:0] level_onehot(input logic [LEVEL_WIDTH-1:0] level);
        logic [IR_COUNT-1:0] mask;
        mask        = '0;
        mask[level] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/interrupt_acknowledge_control_priority_resolver.sv
// Lowest-set-bit finder: IR0 has the highest priority.
// valid is low when no request bit is set; index is then 0.
module priority_resolver
    import interrupt_acknowledge_control_pkg::*;
(
    input  logic [IR_COUNT-1:0]    request,
    output logic                   valid,
    output logic [LEVEL_WIDTH-1:0] index
);

    // Scan upwards and keep the first set bit found.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < IR_COUNT; i++) begin
            if (request[i] && !valid) begin
                valid = 1'b1;
                index = LEVEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_acknowledge_control.sv
// Interrupt acknowledge controller: raises INT for the highest-priority
// unmasked request that may nest above the current in-service level, runs
// the two-pulse INTA handshake, maintains the in-service register and
// drives the vector during the second acknowledge pulse.
module interrupt_acknowledge_control
    import interrupt_acknowledge_control_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   write_initial_command_word_1_reset,
    input  logic [IR_COUNT-1:0]    interrupt_request_register,
    input  logic [IR_COUNT-1:0]    interrupt_mask,
    input  logic [4:0]             interrupt_vector_base,
    input  logic                   auto_end_of_interrupt_config,
    input  logic                   end_of_interrupt,
    input  logic                   interrupt_acknowledge_n,
    output logic                   interrupt_to_cpu,
    output logic                   freeze,
    output logic [IR_COUNT-1:0]    clear_interrupt_request,
    output logic [IR_COUNT-1:0]    in_service_register,
    output logic [7:0]             vector_out,
    output logic                   vector_out_enable
);

    ack_state_t                state;
    logic [LEVEL_WIDTH-1:0]    latched_level;
    logic                      latched_spurious;

    logic [IR_COUNT-1:0]       eligible;
    logic                      candidate_valid;
    logic [LEVEL_WIDTH-1:0]    candidate_index;
    logic                      isr_valid;
    logic [LEVEL_WIDTH-1:0]    isr_index;
    logic                      serviceable;
    logic [IR_COUNT-1:0]       isr_after_eoi;

    // Unmasked pending requests.
    always_comb begin
        eligible = interrupt_request_register & ~interrupt_mask;
    end

    priority_resolver u_candidate_resolver (
        .request (eligible),
        .valid   (candidate_valid),
        .index   (candidate_index)
    );

    priority_resolver u_isr_resolver (
        .request (in_service_register),
        .valid   (isr_valid),
        .index   (isr_index)
    );

    // Fully nested: a candidate only counts if it outranks every level in service.
    always_comb begin
        serviceable = candidate_valid && (!isr_valid || (candidate_index < isr_index));
    end

    // ISR with a non-specific EOI applied to the highest level in service;
    // the FSM layers any set/auto-clear for this edge on top of it.
    always_comb begin
        isr_after_eoi = in_service_register;
        if (end_of_interrupt && isr_valid) begin
            isr_after_eoi[isr_index] = 1'b0;
        end
    end

    // Acknowledge handshake, ISR maintenance and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            in_service_register     <= '0;
            vector_out              <= '0;
            vector_out_enable       <= 1'b0;
            latched_level           <= '0;
            latched_spurious        <= 1'b0;
        end else if (write_initial_command_word_1_reset) begin
            state                   <= IDLE;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            in_service_register     <= '0;
            vector_out              <= '0;
            vector_out_enable       <= 1'b0;
            latched_level           <= '0;
            latched_spurious        <= 1'b0;
        end else begin
            clear_interrupt_request <= '0;
            in_service_register     <= isr_after_eoi;

            unique case (state)
                IDLE: begin
                    // INTA while idle is deliberately ignored.
                    if (serviceable) begin
                        state            <= INT_PENDING;
                        interrupt_to_cpu <= 1'b1;
                    end
                end

                INT_PENDING: begin
                    if (!interrupt_acknowledge_n) begin
                        state            <= ACK1;
                        interrupt_to_cpu <= 1'b0;
                        freeze           <= 1'b1;
                        if (serviceable) begin
                            latched_level           <= candidate_index;
                            latched_spurious        <= 1'b0;
                            in_service_register     <= isr_after_eoi | level_onehot(candidate_index);
                            clear_interrupt_request <= level_onehot(candidate_index);
                        end else begin
                            latched_level    <= SPURIOUS_INDEX;
                            latched_spurious <= 1'b1;
                        end
                    end else if (!serviceable) begin
                        state            <= IDLE;
                        interrupt_to_cpu <= 1'b0;
                    end
                end

                ACK1: begin
                    if (interrupt_acknowledge_n) begin
                        state <= WAIT2;
                    end
                end

                WAIT2: begin
                    if (!interrupt_acknowledge_n) begin
                        state             <= ACK2;
                        vector_out        <= {interrupt_vector_base, latched_level};
                        vector_out_enable <= 1'b1;
                    end
                end

                ACK2: begin
                    if (interrupt_acknowledge_n) begin
                        state             <= IDLE;
                        freeze            <= 1'b0;
                        vector_out        <= '0;
                        vector_out_enable <= 1'b0;
                        if (auto_end_of_interrupt_config && !latched_spurious) begin
                            in_service_register <= isr_after_eoi & ~level_onehot(latched_level);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_control.sv
// Bench for interrupt_acknowledge_control: directed INTA sequences, a
// cycle-level reference model, and literal expectations at key points.
module tb_interrupt_acknowledge_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       icw1;
    logic [7:0] irr;
    logic [7:0] mask;
    logic [4:0] base;
    logic       aeoi;
    logic       eoi;
    logic       inta_n;

    logic       int_cpu;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] isr;
    logic [7:0] vec;
    logic       voe;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    interrupt_acknowledge_control dut (
        .clock                              (clock),
        .reset_n                            (reset_n),
        .write_initial_command_word_1_reset (icw1),
        .interrupt_request_register         (irr),
        .interrupt_mask                     (mask),
        .interrupt_vector_base              (base),
        .auto_end_of_interrupt_config       (aeoi),
        .end_of_interrupt                   (eoi),
        .interrupt_acknowledge_n            (inta_n),
        .interrupt_to_cpu                   (int_cpu),
        .freeze                             (frz),
        .clear_interrupt_request            (clr),
        .in_service_register                (isr),
        .vector_out                         (vec),
        .vector_out_enable                  (voe)
    );

    // ---------------- reference model ----------------
    // m_phase counts progress through one acknowledge:
    // 0 quiet, 1 INT raised, 2 first INTA low, 3 between INTAs, 4 second INTA low.
    int         m_phase = 0;
    logic       m_int   = 1'b0;
    logic [7:0] m_isr   = '0;
    logic [7:0] m_clr   = '0;
    logic [7:0] m_vec   = '0;
    logic       m_voe   = 1'b0;
    int         m_lvl   = 0;
    logic       m_spur  = 1'b0;

    // Position of the lowest set bit, 8 when empty.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    int         cand;
    int         isr_top;
    logic       can_serve;
    logic [7:0] isr_eoi;

    always_comb begin
        cand      = lowest(irr & ~mask);
        isr_top   = lowest(m_isr);
        can_serve = (cand < 8) && (cand < isr_top);
        isr_eoi   = m_isr;
        if (eoi && isr_top < 8) isr_eoi[isr_top] = 1'b0;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || icw1) begin
            m_phase <= 0;
            m_int   <= 1'b0;
            m_isr   <= '0;
            m_clr   <= '0;
            m_vec   <= '0;
            m_voe   <= 1'b0;
            m_lvl   <= 0;
            m_spur  <= 1'b0;
        end else begin
            m_clr <= '0;
            m_isr <= isr_eoi;
            case (m_phase)
                0: if (can_serve) begin
                    m_phase <= 1;
                    m_int   <= 1'b1;
                end
                1: if (!inta_n) begin
                    m_phase <= 2;
                    m_int   <= 1'b0;
                    m_spur  <= !can_serve;
                    m_lvl   <= can_serve ? cand : 7;
                    if (can_serve) begin
                        m_isr <= isr_eoi | (8'd1 << cand);
                        m_clr <= 8'd1 << cand;
                    end
                end else if (!can_serve) begin
                    m_phase <= 0;
                    m_int   <= 1'b0;
                end
                2: if (inta_n) m_phase <= 3;
                3: if (!inta_n) begin
                    m_phase <= 4;
                    m_vec   <= {base, 3'(m_lvl)};
                    m_voe   <= 1'b1;
                end
                4: if (inta_n) begin
                    m_phase <= 0;
                    m_vec   <= '0;
                    m_voe   <= 1'b0;
                    if (aeoi && !m_spur) m_isr <= isr_eoi & ~(8'd1 << m_lvl);
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Advance n cycles, checking every output against the model on each
    // falling edge; returns 2 time units after the following rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cmp("model int_to_cpu", {7'b0, int_cpu}, {7'b0, m_int});
            cmp("model freeze",     {7'b0, frz},     {7'b0, (m_phase >= 2)});
            cmp("model clear",      clr,             m_clr);
            cmp("model isr",        isr,             m_isr);
            cmp("model vector",     vec,             m_vec);
            cmp("model vector_en",  {7'b0, voe},     {7'b0, m_voe});
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        icw1    = 1'b0;
        irr     = '0;
        mask    = '0;
        base    = 5'h11;
        aeoi    = 1'b0;
        eoi     = 1'b0;
        inta_n  = 1'b1;
        tick(2);
        cmp("reset int", {7'b0, int_cpu}, 8'h00);
        cmp("reset isr", isr, 8'h00);
        cmp("reset vec", vec, 8'h00);
        reset_n = 1'b1;
        tick(1);

        // Masked request and INTA while idle: nothing happens.
        mask = 8'h04; irr = 8'h04; inta_n = 1'b0;
        tick(2);
        cmp("masked int", {7'b0, int_cpu}, 8'h00);
        cmp("idle inta freeze", {7'b0, frz}, 8'h00);

        // Basic acknowledge of IR2, base 0x11.
        mask = 8'h00; inta_n = 1'b1;
        tick(1);
        cmp("ir2 int", {7'b0, int_cpu}, 8'h01);
        inta_n = 1'b0;
        tick(1);
        cmp("ir2 clear", clr, 8'h04);
        cmp("ir2 isr", isr, 8'h04);
        cmp("ir2 freeze", {7'b0, frz}, 8'h01);
        irr = 8'h00; inta_n = 1'b1;
        tick(1);
        cmp("ir2 clear one cycle", clr, 8'h00);
        inta_n = 1'b0;
        tick(1);
        cmp("ir2 vector", vec, 8'h8A);
        cmp("ir2 vector_en", {7'b0, voe}, 8'h01);
        inta_n = 1'b1;
        tick(1);
        cmp("ir2 vec after", vec, 8'h00);
        cmp("ir2 isr kept", isr, 8'h04);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        cmp("ir2 eoi", isr, 8'h00);

        // Nesting: IR4 first, IR5 withheld until EOI.
        irr = 8'h30;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("ir4 isr", isr, 8'h10);
        cmp("ir4 clear", clr, 8'h10);
        irr = 8'h20; inta_n = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("ir4 vector", vec, 8'h8C);
        inta_n = 1'b1;
        tick(3);
        cmp("ir5 withheld", {7'b0, int_cpu}, 8'h00);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        cmp("ir4 eoi", isr, 8'h00);
        tick(1);
        cmp("ir5 int", {7'b0, int_cpu}, 8'h01);
        irr = 8'h00;
        tick(1);
        cmp("ir5 withdrawn", {7'b0, int_cpu}, 8'h00);

        // Request drops before INTA, then a spurious acknowledge.
        irr = 8'h02;
        tick(1);
        irr = 8'h00;
        tick(1);
        cmp("ir1 dropped", {7'b0, int_cpu}, 8'h00);
        irr = 8'h02;
        tick(1);
        irr = 8'h00; inta_n = 1'b0;
        tick(1);
        cmp("spur freeze", {7'b0, frz}, 8'h01);
        cmp("spur clear", clr, 8'h00);
        inta_n = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("spur vector", vec, 8'h8F);
        inta_n = 1'b1;
        tick(1);
        cmp("spur isr", isr, 8'h00);

        // Auto-EOI on IR0.
        aeoi = 1'b1; irr = 8'h01;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("aeoi isr set", isr, 8'h01);
        irr = 8'h00; inta_n = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("aeoi isr ack2", isr, 8'h01);
        cmp("aeoi vector", vec, 8'h88);
        inta_n = 1'b1;
        tick(1);
        cmp("aeoi isr cleared", isr, 8'h00);
        aeoi = 1'b0;

        // EOI coinciding with the ISR set for IR1 while IR3 is in service.
        irr = 8'h08;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        irr = 8'h00; inta_n = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        inta_n = 1'b1;
        tick(1);
        cmp("ir3 isr", isr, 8'h08);
        irr = 8'h02;
        tick(1);
        cmp("ir1 nested int", {7'b0, int_cpu}, 8'h01);
        inta_n = 1'b0; eoi = 1'b1;
        tick(1);
        cmp("eoi+set isr", isr, 8'h02);
        cmp("eoi+set clear", clr, 8'h02);
        eoi = 1'b0; irr = 8'h00; inta_n = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        cmp("ir1 vector", vec, 8'h89);
        inta_n = 1'b1;
        tick(1);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        cmp("ir1 eoi", isr, 8'h00);

        // Asynchronous reset in WAIT2.
        irr = 8'h04;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        irr = 8'h00; inta_n = 1'b1;
        tick(1);
        cmp("wait2 freeze", {7'b0, frz}, 8'h01);
        reset_n = 1'b0;
        #1;
        cmp("async rst freeze", {7'b0, frz}, 8'h00);
        cmp("async rst isr", isr, 8'h00);
        cmp("async rst vec", {vec[7:1], voe}, 8'h00);
        tick(1);
        reset_n = 1'b1;

        // Synchronous re-initialise in WAIT2.
        irr = 8'h04;
        tick(1);
        inta_n = 1'b0;
        tick(1);
        irr = 8'h00; inta_n = 1'b1;
        tick(1);
        icw1 = 1'b1;
        #1;
        cmp("icw1 not yet", {7'b0, frz}, 8'h01);
        tick(1);
        icw1 = 1'b0;
        cmp("icw1 freeze", {7'b0, frz}, 8'h00);
        cmp("icw1 isr", isr, 8'h00);
        cmp("icw1 int", {7'b0, int_cpu}, 8'h00);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_acknowledge_control.md
INTERRUPT_ACKNOWLEDGE_CONTROL -- requirements
Module: interrupt_acknowledge_control

Interface
REQ-001: The block SHALL have no parameters; IR count is fixed at 8.
REQ-002: clock  in  1  single clock; all state updates on rising edge.
REQ-003: reset_n  in  1  asynchronous, active-low reset.
REQ-004: write_initial_command_word_1_reset  in  1  synchronous re-initialise pulse.
REQ-005: interrupt_request_register  in  8  pending requests from int_req.
REQ-006: interrupt_mask  in  8  1 = IR masked.
REQ-007: interrupt_vector_base  in  5  vector bits T7..T3.
REQ-008: auto_end_of_interrupt_config  in  1  1 = AEOI mode.
REQ-009: end_of_interrupt  in  1  one-cycle non-specific EOI pulse.
REQ-010: interrupt_acknowledge_n  in  1  CPU INTA#, active-low, already synchronous to clock.
REQ-011: interrupt_to_cpu  out  1  INT request to CPU, registered.
REQ-012: freeze  out  1  holds int_req contents during acknowledge.
REQ-013: clear_interrupt_request  out  8  one-hot, one-cycle clear pulse to int_req.
REQ-014: in_service_register  out  8  ISR, registered.
REQ-015: vector_out  out  8  {interrupt_vector_base, level[2:0]}.
REQ-016: vector_out_enable  out  1  1 while the vector is driven.

Function
REQ-017: eligible = interrupt_request_register & ~interrupt_mask; the candidate is the lowest-index set bit of eligible (IR0 highest priority).
REQ-018: A candidate SHALL be serviceable only if its index is lower than the lowest-index set ISR bit (fully nested); ISR = 0 allows any candidate.
REQ-019: States: IDLE, INT_PENDING, ACK1, WAIT2, ACK2.
REQ-020: IDLE -> INT_PENDING when a serviceable candidate exists; interrupt_to_cpu = 1 from the next cycle.
REQ-021: INT_PENDING -> IDLE, with interrupt_to_cpu dropped, if no serviceable candidate remains and interrupt_acknowledge_n = 1.
REQ-022: INT_PENDING with interrupt_acknowledge_n = 0 -> ACK1: latch the candidate index, set its ISR bit, pulse its clear_interrupt_request bit for one cycle, and assert freeze; interrupt_to_cpu = 0.
REQ-023: Spurious case: with no serviceable candidate at that first INTA low, the latched index SHALL be 7, and no ISR or clear bit SHALL be touched.
REQ-024: ACK1 -> WAIT2 on interrupt_acknowledge_n = 1; WAIT2 -> ACK2 on interrupt_acknowledge_n = 0.
REQ-025: In ACK2, vector_out = {interrupt_vector_base, latched index} and vector_out_enable = 1; both are registered, valid from the first ACK2 cycle.
REQ-026: ACK2 -> IDLE on interrupt_acknowledge_n = 1; freeze, vector_out_enable and vector_out return to 0.
REQ-027: With auto_end_of_interrupt_config = 1, the latched ISR bit SHALL clear on the ACK2 -> IDLE transition (never for spurious).
REQ-028: end_of_interrupt SHALL clear the lowest-index set ISR bit, evaluated on the pre-edge ISR; with ISR = 0 it has no effect.
REQ-029: When end_of_interrupt coincides with an ISR set (REQ-022), both SHALL apply in the same edge.
REQ-030: freeze SHALL be 1 exactly in ACK1, WAIT2 and ACK2.
REQ-031: interrupt_acknowledge_n = 0 in IDLE SHALL be ignored.

Reset
REQ-032: reset_n = 0 SHALL asynchronously force IDLE and zero every output and the latched index.
REQ-033: write_initial_command_word_1_reset SHALL do the same synchronously, overriding all other events, including mid-acknowledge.

Structure
REQ-034: A shared package SHALL hold the state enum, the IR count (8) and the spurious index (7).
REQ-035: The block SHALL instantiate one sub-module, priority_resolver: an 8-bit lowest-set-bit finder with a valid flag, used for both candidate and ISR selection.

Verification
REQ-036: IRR = 0x04, mask = 0, base = 0x11 -> INT; two INTA pulses -> clear = 0x04 for one cycle, ISR = 0x04, vector_out = 0x8A.
REQ-037: IRR = 0x30 -> IR4 is serviced first; the INT for IR5 is withheld while ISR = 0x10; EOI -> ISR = 0, INT reasserts for IR5.
REQ-038: IRR = 0x02 drops before INTA -> INT falls; force the first INTA while no request is present -> spurious vector {base, 3'b111}, ISR unchanged.
REQ-039: AEOI = 1, IRR = 0x01 -> ISR = 0x01 during acknowledge and 0x00 after the second INTA rises.
REQ-040: ISR = 0x08, EOI in the same cycle as the first INTA for IR1 -> ISR = 0x02.
REQ-041: reset_n low in WAIT2 -> IDLE, all outputs 0 immediately; repeat with write_initial_command_word_1_reset -> same at the next edge.
